// File: rtl/depth_fetch_unit.sv
// depth_fetch_unit: depth-buffer fetch stage between fragment generation and depth test.
// Each accepted fragment issues one Avalon-MM read of its stored depth. Its side data is
// parked in a FIFO, and each in-order read response is paired with its fragment downstream.
//
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   master_*                     Avalon-MM read master (write side tied off)
//   input_valid, done_in         upstream fragment / end-of-primitive token
//   addr_in, color_in, depth_in  upstream fragment fields
//   stall_out                    upstream must hold
//   stall_in                     downstream backpressure
//   output_valid, *_out          paired fragment + old depth
//   done_out                     one-cycle done token
//   protocol_error               sticky: response with nothing outstanding
module depth_fetch_unit #(
  parameter int unsigned ADDR_W          = 26,
  parameter int unsigned DEPTH_W         = 32,
  parameter int unsigned COLOR_W         = 24,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned DEPTH_OFFSET    = 4,
  parameter logic [3:0]  BE_MASK         = 4'hF
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  master_address,
  output logic               master_read,
  output logic               master_write,
  output logic [3:0]         master_byteenable,
  output logic [31:0]        master_writedata,
  input  logic [DEPTH_W-1:0] master_readdata,
  input  logic               master_readdatavalid,
  input  logic               master_waitrequest,
  input  logic               input_valid,
  input  logic               done_in,
  output logic               stall_out,
  input  logic [ADDR_W-1:0]  addr_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic [DEPTH_W-1:0] depth_in,
  input  logic               stall_in,
  output logic               output_valid,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [COLOR_W-1:0] color_out,
  output logic [DEPTH_W-1:0] new_depth_out,
  output logic [DEPTH_W-1:0] old_depth_out,
  output logic               done_out,
  output logic               protocol_error
);

  localparam int unsigned PtrW  = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned SideW = ADDR_W + COLOR_W + DEPTH_W;

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e                state_q, state_d;
  logic                  master_read_q;
  logic [ADDR_W-1:0]     master_addr_q;
  logic                  proto_err_q;

  logic [SideW-1:0]      side_mem_q [MAX_OUTSTANDING];
  logic [DEPTH_W-1:0]    resp_mem_q [MAX_OUTSTANDING];
  logic [PtrW-1:0]       side_wr_q, side_rd_q, resp_wr_q, resp_rd_q;
  logic [CntW-1:0]       side_cnt_q, resp_cnt_q, outstanding;

  logic side_full, side_empty, resp_empty, done_pending;
  logic accept, done_acc, resp_push, proto_hit, out_valid, pop, drain_done;
  logic [SideW-1:0] side_head;

  assign side_full    = (side_cnt_q == CntW'(MAX_OUTSTANDING));
  assign side_empty   = (side_cnt_q == '0);
  assign resp_empty   = (resp_cnt_q == '0);
  assign done_pending = (state_q == StDrain);

  assign stall_out = side_full | (master_read_q & master_waitrequest) | done_pending;
  assign accept    = input_valid & ~stall_out;
  assign done_acc  = done_in & ~stall_out;

  // Accepted-but-unanswered fragments; includes a fragment whose read is not yet issued.
  assign outstanding = side_cnt_q - resp_cnt_q;
  assign resp_push   = master_readdatavalid & (outstanding != '0);
  assign proto_hit   = master_readdatavalid & (outstanding == '0);

  assign out_valid  = ~side_empty & ~resp_empty;
  assign pop        = out_valid & ~stall_in;
  assign drain_done = done_pending & side_empty & ~master_read_q;

  always_comb begin
    state_d  = state_q;
    done_out = 1'b0;
    unique case (state_q)
      StIdle:  if (accept) state_d = StReq;
      StReq:   if (!master_waitrequest && !accept) state_d = StIdle;
      StDrain: begin
        if (drain_done) begin
          done_out = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A fragment accepted alongside done still gets its read; the read flag tracks it.
    if (done_acc) state_d = StDrain;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      master_read_q <= 1'b0;
      master_addr_q <= '0;
      proto_err_q   <= 1'b0;
      side_wr_q     <= '0;
      side_rd_q     <= '0;
      resp_wr_q     <= '0;
      resp_rd_q     <= '0;
      side_cnt_q    <= '0;
      resp_cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      // Accept is only possible when no read is stalled, so one request register suffices.
      master_read_q <= accept | (master_read_q & master_waitrequest);
      if (accept) master_addr_q <= addr_in + ADDR_W'(DEPTH_OFFSET);
      if (proto_hit) proto_err_q <= 1'b1;
      if (accept)    side_wr_q <= side_wr_q + PtrW'(1);
      if (pop)       side_rd_q <= side_rd_q + PtrW'(1);
      if (resp_push) resp_wr_q <= resp_wr_q + PtrW'(1);
      if (pop)       resp_rd_q <= resp_rd_q + PtrW'(1);
      side_cnt_q <= side_cnt_q + CntW'(accept) - CntW'(pop);
      resp_cnt_q <= resp_cnt_q + CntW'(resp_push) - CntW'(pop);
    end
  end

  // Storage needs no reset; pointers and counts define validity.
  always_ff @(posedge clock) begin
    if (accept)    side_mem_q[side_wr_q] <= {addr_in, color_in, depth_in};
    if (resp_push) resp_mem_q[resp_wr_q] <= master_readdata;
  end

  assign side_head = side_mem_q[side_rd_q];

  assign master_address    = master_addr_q;
  assign master_read       = master_read_q;
  assign master_write      = 1'b0;
  assign master_byteenable = BE_MASK;
  assign master_writedata  = '0;
  assign protocol_error    = proto_err_q;

  // Fields forced to zero when not valid so stale storage never leaks out.
  assign output_valid  = out_valid;
  assign addr_out      = out_valid ? side_head[SideW-1 -: ADDR_W] : '0;
  assign color_out     = out_valid ? side_head[DEPTH_W +: COLOR_W] : '0;
  assign new_depth_out = out_valid ? side_head[DEPTH_W-1:0] : '0;
  assign old_depth_out = out_valid ? resp_mem_q[resp_rd_q] : '0;

endmodule

// File: tb/tb_depth_fetch_unit.sv
module tb_depth_fetch_unit;

  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 24;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] master_address;
  logic          master_read, master_write;
  logic [3:0]    master_byteenable;
  logic [31:0]   master_writedata;
  logic [DW-1:0] master_readdata;
  logic          master_readdatavalid;
  logic          master_waitrequest;
  logic          input_valid, done_in, stall_out, stall_in;
  logic [AW-1:0] addr_in, addr_out;
  logic [CW-1:0] color_in, color_out;
  logic [DW-1:0] depth_in, new_depth_out, old_depth_out;
  logic          output_valid, done_out, protocol_error;

  // Slave model: fixed one-cycle response latency after an accepted read.
  logic          slave_rdv = 1'b0;
  logic [DW-1:0] slave_data = '0;
  logic          man_rdv = 1'b0;
  logic [DW-1:0] man_data = '0;
  int            reads_issued = 0;
  int            done_cnt = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  assign master_readdatavalid = slave_rdv | man_rdv;
  assign master_readdata      = man_rdv ? man_data : slave_data;

  always #5 clock = ~clock;

  depth_fetch_unit dut (
    .clock                (clock),
    .reset                (reset),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_write         (master_write),
    .master_byteenable    (master_byteenable),
    .master_writedata     (master_writedata),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest),
    .input_valid          (input_valid),
    .done_in              (done_in),
    .stall_out            (stall_out),
    .addr_in              (addr_in),
    .color_in             (color_in),
    .depth_in             (depth_in),
    .stall_in             (stall_in),
    .output_valid         (output_valid),
    .addr_out             (addr_out),
    .color_out            (color_out),
    .new_depth_out        (new_depth_out),
    .old_depth_out        (old_depth_out),
    .done_out             (done_out),
    .protocol_error       (protocol_error)
  );

  function automatic logic [31:0] mem_f(input logic [AW-1:0] a);
    return 32'hDEAD_BEEF + 32'(a) - 32'h104;
  endfunction

  always @(posedge clock) begin
    slave_rdv  <= !reset && master_read && !master_waitrequest;
    slave_data <= mem_f(master_address);
    if (!reset && master_read && !master_waitrequest) reads_issued <= reads_issued + 1;
    if (done_out) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait (bounded) for an output, check it, then let it pop on the next edge.
  task automatic wait_out(input logic [AW-1:0] a);
    int n = 0;
    while (!output_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq("out_timeout", 64'(n < 20), 64'd1);
    check_eq("out_addr", 64'(addr_out), 64'(a));
    check_eq("out_old", 64'(old_depth_out), 64'(mem_f(a + AW'(4))));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    reset = 1'b1; master_waitrequest = 1'b0; input_valid = 1'b0; done_in = 1'b0;
    addr_in = '0; color_in = '0; depth_in = '0; stall_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("rst_valid", 64'(output_valid), 64'd0);
    check_eq("rst_stall", 64'(stall_out), 64'd0);
    check_eq("rst_read", 64'(master_read), 64'd0);
    check_eq("rst_perr", 64'(protocol_error), 64'd0);
    check_eq("rst_be", 64'(master_byteenable), 64'hF);

    // 1) single fragment, minimum latency
    tick();
    input_valid = 1'b1; addr_in = 26'h100; color_in = 24'hABCDEF; depth_in = 32'h1234;
    #1 check_eq("t1_stall", 64'(stall_out), 64'd0);
    tick();                                  // N accepted
    input_valid = 1'b0;
    #1;
    check_eq("t1_read", 64'(master_read), 64'd1);
    check_eq("t1_addr", 64'(master_address), 64'h104);
    check_eq("t1_v1", 64'(output_valid), 64'd0);
    tick();                                  // N+2
    check_eq("t1_rdclr", 64'(master_read), 64'd0);
    check_eq("t1_v2", 64'(output_valid), 64'd0);
    tick();                                  // N+3
    check_eq("t1_v3", 64'(output_valid), 64'd1);
    check_eq("t1_old", 64'(old_depth_out), 64'hDEADBEEF);
    check_eq("t1_aout", 64'(addr_out), 64'h100);
    check_eq("t1_col", 64'(color_out), 64'hABCDEF);
    check_eq("t1_new", 64'(new_depth_out), 64'h1234);
    tick();
    check_eq("t1_pop", 64'(output_valid), 64'd0);

    // 2) eight back-to-back under downstream stall
    stall_in = 1'b1;
    r0 = reads_issued;
    for (int i = 0; i < 8; i++) begin
      input_valid = 1'b1; addr_in = 26'h200 + AW'(16 * i);
      color_in = CW'(i); depth_in = ~DW'(i);
      #1 check_eq("t2_acc_stall", 64'(stall_out), 64'd0);
      tick();
    end
    addr_in = 26'h280;
    #1 check_eq("t2_full_stall", 64'(stall_out), 64'd1);
    input_valid = 1'b0;
    tick(); tick(); tick();
    check_eq("t2_reads", 64'(reads_issued - r0), 64'd8);
    check_eq("t2_hold_valid", 64'(output_valid), 64'd1);
    stall_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("t2_valid", 64'(output_valid), 64'd1);
      check_eq("t2_addr", 64'(addr_out), 64'(26'h200 + AW'(16 * i)));
      check_eq("t2_col", 64'(color_out), 64'(i));
      check_eq("t2_old", 64'(old_depth_out), 64'(mem_f(26'h204 + AW'(16 * i))));
      tick();
    end
    check_eq("t2_empty", 64'(output_valid), 64'd0);
    check_eq("t2_unstall", 64'(stall_out), 64'd0);

    // 3) waitrequest held three cycles on the first read
    r0 = reads_issued;
    master_waitrequest = 1'b1;
    input_valid = 1'b1; addr_in = 26'h300;
    tick();
    addr_in = 26'h310;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("t3_read", 64'(master_read), 64'd1);
      check_eq("t3_addr", 64'(master_address), 64'h304);
      check_eq("t3_stall", 64'(stall_out), 64'd1);
      tick();
    end
    check_eq("t3_noread", 64'(reads_issued - r0), 64'd0);
    master_waitrequest = 1'b0;
    #1 check_eq("t3_release", 64'(stall_out), 64'd0);
    tick();
    input_valid = 1'b0;
    #1;
    check_eq("t3_read2", 64'(master_read), 64'd1);
    check_eq("t3_addr2", 64'(master_address), 64'h314);
    wait_out(26'h300);
    wait_out(26'h310);

    // 4) done with the last of four fragments
    stall_in = 1'b1;
    r0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      input_valid = 1'b1; addr_in = 26'h400 + AW'(16 * i); done_in = (i == 3);
      tick();
    end
    done_in = 1'b0; addr_in = 26'h4F0;
    #1 check_eq("t4_stall", 64'(stall_out), 64'd1);
    tick(); tick(); tick(); tick();
    check_eq("t4_stall_hold", 64'(stall_out), 64'd1);
    check_eq("t4_nodone", 64'(done_cnt - r0), 64'd0);
    stall_in = 1'b0;
    for (int i = 0; i < 4; i++) wait_out(26'h400 + AW'(16 * i));
    check_eq("t4_done", 64'(done_out), 64'd1);
    check_eq("t4_stall_done", 64'(stall_out), 64'd1);
    tick();
    check_eq("t4_done_clr", 64'(done_out), 64'd0);
    check_eq("t4_resume", 64'(stall_out), 64'd0);
    tick();
    input_valid = 1'b0;
    wait_out(26'h4F0);
    check_eq("t4_done_once", 64'(done_cnt - r0), 64'd1);

    // 5) spurious response
    man_data = 32'h55; man_rdv = 1'b1;
    tick();
    man_rdv = 1'b0;
    #1;
    check_eq("t5_perr", 64'(protocol_error), 64'd1);
    check_eq("t5_valid", 64'(output_valid), 64'd0);
    tick(); tick(); tick();
    check_eq("t5_sticky", 64'(protocol_error), 64'd1);
    check_eq("t5_valid2", 64'(output_valid), 64'd0);

    // 6) reset with three in flight
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      input_valid = 1'b1; addr_in = 26'h600 + AW'(16 * i);
      tick();
    end
    input_valid = 1'b0;
    tick(); tick(); tick();
    check_eq("t6_pre_valid", 64'(output_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("t6_valid", 64'(output_valid), 64'd0);
    check_eq("t6_stall", 64'(stall_out), 64'd0);
    check_eq("t6_perr", 64'(protocol_error), 64'd0);
    tick();
    check_eq("t6_empty", 64'(output_valid), 64'd0);
    check_eq("t6_read", 64'(master_read), 64'd0);
    stall_in = 1'b0;
    input_valid = 1'b1; addr_in = 26'h700;
    tick();
    input_valid = 1'b0;
    wait_out(26'h700);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
